// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port RAM between instruction fetch and the MEM-stage data port.
// Latency: grant registered; ram_req rises 1 cycle after the request; completion on ram_ack.
// Backpressure: the waiting requester is stalled until its valid pulse; data wins, IF starvation bounded.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic [1:0]        mem_ctrl_input,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_valid,
  output logic              mem_stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             dreq;
  logic             grant_d;
  logic             grant_i;
  logic [CNT_W-1:0] starve_cnt;

  // Only load (10) and store (01) encodings are real data accesses.
  assign dreq = (mem_ctrl_input == 2'b01) || (mem_ctrl_input == 2'b10);

  // Arbitration in IDLE (forced IF when starved, else data first); wait for ack otherwise.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && (starve_cnt == LIMIT)) begin
          grant_i   = 1'b1;
          state_nxt = I_ACC;
        end else if (dreq) begin
          grant_d   = 1'b1;
          state_nxt = D_ACC;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_nxt = I_ACC;
        end
      end
      D_ACC, I_ACC: begin
        if (ram_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // RAM request registers: loaded on grant, held through the access, req dropped on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (grant_d) begin
      ram_req   <= 1'b1;
      ram_we    <= (mem_ctrl_input == 2'b01);
      ram_addr  <= address;
      ram_wdata <= w_data;
    end else if (grant_i) begin
      ram_req   <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= if_addr;
    end else if ((state != IDLE) && ram_ack) begin
      ram_req   <= 1'b0;
    end
  end

  // Count data grants that overtook a waiting fetch; any fetch grant clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Completion pulses and returned data only when an access of that kind is acked.
  assign mem_valid = (state == D_ACC) && ram_ack;
  assign if_valid  = (state == I_ACC) && ram_ack;
  assign read_data = mem_valid ? ram_rdata : '0;
  assign if_rdata  = if_valid  ? ram_rdata : '0;

  // A requester stalls from the moment it asks until its own completion cycle.
  assign mem_stall = dreq   && !mem_valid;
  assign if_stall  = if_req && !if_valid;

endmodule
